cpu_core_p: RTL and testbench
=============================

CPU_CORE_P -- requirements
Module: cpu_core_p

Interface
REQ-001 AW, 5, address width in bits; addressable words = 2^AW; SHALL satisfy DW >= AW+3.
REQ-002 DW, 8, data and instruction word width; opcode = data[DW-1:DW-3], operand address = data[AW-1:0].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous reset, active-low.
REQ-005 mem_ready  in  1  memory handshake; the current rd/wr access completes on an edge where it is 1.
REQ-006 data  inout  DW  shared bus; driven with acc only while wr=1, high-Z otherwise.
REQ-007 addr  out  AW  memory address: pc during fetch, ir_addr during execute.
REQ-008 rd  out  1  read strobe; wr  out  1  write strobe.
REQ-009 fetch  out  1  high while in FETCH; halt  out  1  high in HALT.
REQ-010 opcode  out  3  opcode field of IR; ir_addr  out  AW  operand field of IR; pc_addr  out  AW  program counter.

Function
REQ-011 States SHALL be FETCH, DECODE, READ, WRITE and HALT; outputs SHALL decode from registered state only, with no combinational path from mem_ready.
REQ-012 FETCH: rd=1, fetch=1, addr=pc. On an edge with mem_ready=1: IR<=data, pc<=pc+1 mod 2^AW, go to DECODE. Otherwise hold with addr stable.
REQ-013 DECODE is one cycle with rd=wr=0.
REQ-014 Opcode actions in DECODE:
- 000 HLT -> HALT.
- 010 ADD, 011 AND, 100 XOR, 101 LDA -> READ.
- 110 STO -> WRITE.
- 111 JMP -> pc<=ir_addr, then FETCH.
- 001 -> see REQ-022.
REQ-015 READ: rd=1, addr=ir_addr. On the mem_ready edge, acc is updated as follows, then go to FETCH:
- ADD: acc+data mod 2^DW, carry discarded.
- AND: acc&data.
- XOR: acc^data.
- LDA: data.
REQ-016 WRITE: wr=1, addr=ir_addr, data=acc. On the mem_ready edge go to FETCH; wr SHALL drop on that same edge.
REQ-017 HALT SHALL be sticky until reset: halt=1, rd=wr=0, data high-Z, mem_ready ignored, pc and acc frozen.
REQ-018 Wait states of any length SHALL NOT cause a double pc increment, a double acc update or strobe glitches.
REQ-019 rd and wr SHALL never be high in the same cycle.

Reset
REQ-020 While reset=0 at an edge, the core SHALL enter state FETCH-pending with these values; no fetch strobe is asserted until the first edge after reset=1:
- pc=0, acc=0, IR=0.
- rd=wr=fetch=halt=0, addr=0, opcode=000, ir_addr=0, pc_addr=0, data high-Z.
REQ-021 Reset mid-access (including WRITE with mem_ready=0) SHALL abandon the access at that edge with no acc update and no pc update.

Configuration
REQ-022 Macro SKZ_EN controls opcode 001:
- Defined: SKZ. In DECODE, if acc==0 then pc<=pc+1 mod 2^AW; next state FETCH in both cases.
- Undefined: 001 is a NOP, DECODE -> FETCH with no state change.

Verification
(AW=5, DW=8; encoding = opcode<<5 | addr.)
REQ-023 Basic program, mem_ready tied 1:
- mem[0..3]=BA,5B,DC,00; mem[1A]=7F; mem[1B]=85.
- Required: mem[1C]=04, halt=1, pc_addr=04, acc=04.
REQ-024 Wait states: same program with mem_ready low for 3 cycles before every access.
- Required: identical final state.
- Required: rd/wr held high and addr stable throughout each wait, with exactly 4 fetches observed.
REQ-025 JMP and wrap: mem[0]=FF (JMP 1F), mem[1F]=A5 (LDA 05), mem[05]=3C.
- Required: after executing LDA, acc=3C, pc_addr=00, next fetch addr=00.
REQ-026 SKZ, with acc=0 after reset: mem[0..2]=20,00,00.
- SKZ_EN defined: halt with pc_addr=03.
- SKZ_EN undefined: halt with pc_addr=02.
REQ-027 Reset mid-STO: reset=0 while in WRITE with mem_ready=0.
- Required at the next edge: wr=0, data high-Z, pc_addr=00, acc=00.
- Required: target word unchanged.
REQ-028 Halt persistence: after HLT, toggle mem_ready for 20 cycles.
- Required: halt=1, rd=wr=0, pc_addr unchanged.
- Required: after reset pulse, fetch=1 at addr 00.

Source files
------------

// File: rtl/cpu_core_p.sv
// Accumulator CPU core: fetch/decode/read/write/halt sequencer on a shared inout memory bus.
// Latency: 1 fetch access + 1 decode cycle + 0..1 operand access per instruction, plus memory wait states.
// Backpressure: mem_ready low stalls the current rd/wr access with strobes and addr held. Optional SKZ opcode: SKZ_EN.
module cpu_core_p #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_ready,
    inout  wire  [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic          fetch,
    output logic          halt,
    output logic [2:0]    opcode,
    output logic [AW-1:0] ir_addr,
    output logic [AW-1:0] pc_addr
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t        state;
    state_t        next_state;
    logic          run;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [DW-1:0] ir;

    assign opcode  = ir[DW-1 -: 3];
    assign ir_addr = ir[AW-1:0];
    assign pc_addr = pc;
    assign data    = wr ? acc : {DW{1'bz}};

    // Strobes decode from registered state only; mem_ready steers next_state alone.
    always_comb begin
        next_state = state;
        rd         = 1'b0;
        wr         = 1'b0;
        fetch      = 1'b0;
        halt       = 1'b0;
        addr       = pc;
        case (state)
            S_FETCH: begin
                if (run) begin
                    rd    = 1'b1;
                    fetch = 1'b1;
                    if (mem_ready) next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT:                         next_state = S_HALT;
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: next_state = S_READ;
                    OP_STO:                         next_state = S_WRITE;
                    default:                        next_state = S_FETCH;
                endcase
            end
            S_READ: begin
                rd   = 1'b1;
                addr = ir_addr;
                if (mem_ready) next_state = S_FETCH;
            end
            S_WRITE: begin
                wr   = 1'b1;
                addr = ir_addr;
                if (mem_ready) next_state = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // run stays low for the first edge after reset so no strobe appears while reset is still settling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
            run   <= 1'b0;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
        end else begin
            run   <= 1'b1;
            state <= next_state;
            case (state)
                S_FETCH: begin
                    if (run && mem_ready) begin
                        ir <= data;
                        pc <= pc + AW'(1);
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc <= ir_addr;
                    end
`ifdef SKZ_EN
                    if (opcode == OP_SKZ && acc == '0) begin
                        pc <= pc + AW'(1);
                    end
`endif
                end
                S_READ: begin
                    if (mem_ready) begin
                        case (opcode)
                            OP_ADD:  acc <= acc + data;
                            OP_AND:  acc <= acc & data;
                            OP_XOR:  acc <= acc ^ data;
                            default: acc <= data;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_p.sv
// Directed-program bench for cpu_core_p with a behavioural memory and selectable mem_ready pattern.
module tb_cpu_core_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    wire  [7:0] data;
    logic [4:0] addr;
    logic       rd, wr, fetch, halt;
    logic [2:0] opcode;
    logic [4:0] ir_addr, pc_addr;

    logic [7:0] mem      [0:31];
    logic [7:0] init_mem [0:31];
    logic       load = 1'b0;
    int         mode = 0;     // 0: ready tied high, 1: 3 wait states per access, 2: manual
    logic       man_rdy = 1'b1;
    int         wcnt = 0;
    int         fetch_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    logic       p_rd = 1'b0, p_wr = 1'b0, p_rdy = 1'b1;
    logic [4:0] p_addr = '0;

`ifdef SKZ_EN
    localparam logic [4:0] SKZ_PC = 5'd3;
`else
    localparam logic [4:0] SKZ_PC = 5'd2;
`endif

    cpu_core_p #(.AW(5), .DW(8)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .data(data),
        .addr(addr), .rd(rd), .wr(wr), .fetch(fetch), .halt(halt),
        .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr)
    );

    always #5 clk = ~clk;

    assign mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (wcnt == 3) : man_rdy;
    assign data      = (rd && !wr) ? mem[addr] : 8'bz;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
            fetch_cnt <= 0;
        end else begin
            if (wr && mem_ready) mem[addr] <= data;
            if (fetch && mem_ready) fetch_cnt <= fetch_cnt + 1;
        end
        if ((rd || wr) && !mem_ready) wcnt <= wcnt + 1;
        else                          wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe exclusivity always; strobe/addr stability across wait cycles in wait-state mode.
    always @(negedge clk) begin
        if (reset) check("rd_wr_exclusive", {31'b0, rd & wr}, 32'd0);
        if (mode == 1 && reset && (p_rd || p_wr) && !p_rdy) begin
            check("wait_rd_held", {31'b0, rd}, {31'b0, p_rd});
            check("wait_wr_held", {31'b0, wr}, {31'b0, p_wr});
            check("wait_addr_stable", {27'b0, addr}, {27'b0, p_addr});
        end
        p_rd   = rd;
        p_wr   = wr;
        p_rdy  = mem_ready;
        p_addr = addr;
    end

    task automatic clear_img();
        for (int i = 0; i < 32; i++) init_mem[i] = 8'h00;
    endtask

    task automatic basic_img();
        clear_img();
        init_mem[0]  = 8'hBA;
        init_mem[1]  = 8'h5B;
        init_mem[2]  = 8'hDC;
        init_mem[3]  = 8'h00;
        init_mem[26] = 8'h7F;
        init_mem[27] = 8'h85;
    endtask

    // Loads memory and applies one reset edge; leaves the bench at a negedge with reset released.
    task automatic start(input int m, input bit chk_rst);
        @(negedge clk);
        mode  = m;
        reset = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (chk_rst) begin
            check("rst_rd", {31'b0, rd}, 32'd0);
            check("rst_wr", {31'b0, wr}, 32'd0);
            check("rst_fetch", {31'b0, fetch}, 32'd0);
            check("rst_halt", {31'b0, halt}, 32'd0);
            check("rst_addr", {27'b0, addr}, 32'd0);
            check("rst_opcode", {29'b0, opcode}, 32'd0);
            check("rst_ir_addr", {27'b0, ir_addr}, 32'd0);
            check("rst_pc_addr", {27'b0, pc_addr}, 32'd0);
            check("rst_acc", {24'b0, dut.acc}, 32'd0);
        end
        reset = 1'b1;
        if (chk_rst) check("pending_no_fetch", {31'b0, fetch}, 32'd0);
        @(negedge clk);
        if (chk_rst) begin
            check("first_fetch", {31'b0, fetch}, 32'd1);
            check("first_fetch_addr", {27'b0, addr}, 32'd0);
        end
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (halt) break;
            @(negedge clk);
        end
        check(tag, {31'b0, halt}, 32'd1);
    endtask

    task automatic basic_results(input string pfx);
        check({pfx, "_mem1c"}, {24'b0, mem[28]}, 32'h04);
        check({pfx, "_pc"}, {27'b0, pc_addr}, 32'h04);
        check({pfx, "_acc"}, {24'b0, dut.acc}, 32'h04);
        check({pfx, "_fetches"}, fetch_cnt, 32'd4);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 32; i++) init_mem[i] = 8'h00;

        // Basic program, ready tied high
        basic_img();
        start(0, 1'b1);
        wait_halt("basic_halt");
        basic_results("basic");

        // Same program with three wait states per access
        basic_img();
        start(1, 1'b0);
        wait_halt("wait_halt");
        basic_results("wait");

        // Halt persistence with mem_ready toggling
        mode = 2;
        for (int i = 0; i < 20; i++) begin
            man_rdy = ~man_rdy;
            @(negedge clk);
            check("hold_halt", {31'b0, halt}, 32'd1);
            check("hold_rd", {31'b0, rd}, 32'd0);
            check("hold_wr", {31'b0, wr}, 32'd0);
            check("hold_pc", {27'b0, pc_addr}, 32'h04);
        end
        check("hold_acc", {24'b0, dut.acc}, 32'h04);
        reset = 1'b0;
        @(negedge clk);
        check("hold_rst_halt", {31'b0, halt}, 32'd0);
        reset = 1'b1;
        man_rdy = 1'b1;
        @(negedge clk);
        check("restart_fetch", {31'b0, fetch}, 32'd1);
        check("restart_addr", {27'b0, addr}, 32'd0);

        // JMP to last word then wrap of pc
        clear_img();
        init_mem[0]  = 8'hFF;
        init_mem[31] = 8'hA5;
        init_mem[5]  = 8'h3C;
        start(0, 1'b0);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (fetch && opcode == 3'b101 && pc_addr == 5'd0) begin
                    found = 1'b1;
                    break;
                end
            end
            check("jmp_reached", {31'b0, found}, 32'd1);
            check("jmp_acc", {24'b0, dut.acc}, 32'h3C);
            check("jmp_pc", {27'b0, pc_addr}, 32'h00);
            check("jmp_fetch_addr", {27'b0, addr}, 32'h00);
        end

        // SKZ (or NOP) with acc zero after reset
        clear_img();
        init_mem[0] = 8'h20;
        start(0, 1'b0);
        wait_halt("skz_halt");
        check("skz_pc", {27'b0, pc_addr}, {27'b0, SKZ_PC});

        // Reset while a STO is stalled
        clear_img();
        init_mem[0]  = 8'hBA;
        init_mem[1]  = 8'hDC;
        init_mem[26] = 8'h7F;
        init_mem[28] = 8'hAA;
        man_rdy = 1'b1;
        start(2, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (wr) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("sto_reached", {31'b0, seen}, 32'd1);
        end
        man_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sto_wr_stalled", {31'b0, wr}, 32'd1);
        check("sto_acc_before", {24'b0, dut.acc}, 32'h7F);
        reset = 1'b0;
        @(negedge clk);
        check("sto_rst_wr", {31'b0, wr}, 32'd0);
        check("sto_rst_rd", {31'b0, rd}, 32'd0);
        check("sto_rst_pc", {27'b0, pc_addr}, 32'h00);
        check("sto_rst_acc", {24'b0, dut.acc}, 32'h00);
        check("sto_target", {24'b0, mem[28]}, 32'hAA);
        reset = 1'b1;
        man_rdy = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
